ram_arbiter: RTL and testbench

- Sequences and shares the single-port RAM block between two requesters: instruction fetch (port A, read-only) and data/load-store (port B, read/write).
- Registers one request at a time and drives the RAM address, data and read/write strobes for a fixed access window.
- Captures read data and returns a one-cycle acknowledge to the requester.
- Sits between the CPU control unit and the RAM block.

---
 rtl/ram_arbiter.sv | 151 +++++++++++++++
 tb/tb_ram_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between an instruction-fetch
// requester (port A, read-only) and a load/store requester (port B, read/write).
// One request is latched at a time, the RAM strobes are held for RAM_WAIT
// cycles, and a one-cycle ack (with err for out-of-range addresses) is returned.
// Optional: define ROUND_ROBIN_EN for alternating grants; otherwise B > A.
module ram_arbiter #(
    parameter int unsigned ADLINES   = 8,
    parameter int unsigned DATALINES = 16,
    parameter int unsigned RAM_SIZE  = 256,
    parameter int unsigned RAM_WAIT  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_req,
    input  logic [ADLINES-1:0]   a_addr,
    output logic                 a_ack,
    output logic                 a_err,
    output logic [DATALINES-1:0] a_rdata,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [ADLINES-1:0]   b_addr,
    input  logic [DATALINES-1:0] b_wdata,
    output logic                 b_ack,
    output logic                 b_err,
    output logic [DATALINES-1:0] b_rdata,
    output logic [ADLINES-1:0]   ram_address,
    output logic [DATALINES-1:0] ram_datain,
    input  logic [DATALINES-1:0] ram_dataout,
    output logic                 ram_read,
    output logic                 ram_write
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(RAM_WAIT - 1);

    state_t               state;
    logic [3:0]           wait_cnt;
    logic                 cmd_sel;   // 1 = port B owns the current access
    logic                 cmd_we;

    logic                 grant_b;
    logic [ADLINES-1:0]   win_addr;
    logic                 win_we;
    logic [DATALINES-1:0] win_wdata;
    logic                 win_oor;

`ifdef ROUND_ROBIN_EN
    logic                 ptr;       // preferred port on a tie: 0 = A, 1 = B
`endif

    // Pick the winning requester and decode its command.
    always_comb begin
`ifdef ROUND_ROBIN_EN
        grant_b = b_req && (!a_req || ptr);
`else
        grant_b = b_req;
`endif
        win_addr  = grant_b ? b_addr : a_addr;
        win_we    = grant_b && b_we;
        win_wdata = win_we ? b_wdata : '0;
        win_oor   = {{(32-ADLINES){1'b0}}, win_addr} >= RAM_SIZE;
    end

    // Access sequencer with registered RAM strobes, acks and read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            cmd_sel     <= 1'b0;
            cmd_we      <= 1'b0;
            a_ack       <= 1'b0;
            a_err       <= 1'b0;
            a_rdata     <= '0;
            b_ack       <= 1'b0;
            b_err       <= 1'b0;
            b_rdata     <= '0;
            ram_address <= '0;
            ram_datain  <= '0;
            ram_read    <= 1'b0;
            ram_write   <= 1'b0;
`ifdef ROUND_ROBIN_EN
            ptr         <= 1'b0;
`endif
        end else begin
            a_ack <= 1'b0;
            a_err <= 1'b0;
            b_ack <= 1'b0;
            b_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        cmd_sel <= grant_b;
                        cmd_we  <= win_we;
`ifdef ROUND_ROBIN_EN
                        ptr     <= !grant_b;
`endif
                        if (win_oor) begin
                            // Out-of-range: no strobes, respond next cycle.
                            state <= RESP;
                            if (grant_b) begin
                                b_ack <= 1'b1;
                                b_err <= 1'b1;
                            end else begin
                                a_ack <= 1'b1;
                                a_err <= 1'b1;
                            end
                        end else begin
                            state       <= ACCESS;
                            wait_cnt    <= '0;
                            ram_address <= win_addr;
                            ram_datain  <= win_wdata;
                            ram_read    <= !win_we;
                            ram_write   <= win_we;
                        end
                    end
                end
                ACCESS: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state       <= RESP;
                        wait_cnt    <= '0;
                        ram_read    <= 1'b0;
                        ram_write   <= 1'b0;
                        ram_address <= '0;
                        ram_datain  <= '0;
                        if (cmd_sel) begin
                            b_ack <= 1'b1;
                            if (!cmd_we) b_rdata <= ram_dataout;
                        end else begin
                            a_ack <= 1'b1;
                            if (!cmd_we) a_rdata <= ram_dataout;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural RAM model.
module tb_ram_arbiter;

    localparam int unsigned ADL = 8;
    localparam int unsigned DL  = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           a_req = 1'b0;
    logic [ADL-1:0] a_addr = '0;
    logic           a_ack, a_err;
    logic [DL-1:0]  a_rdata;
    logic           b_req = 1'b0;
    logic           b_we = 1'b0;
    logic [ADL-1:0] b_addr = '0;
    logic [DL-1:0]  b_wdata = '0;
    logic           b_ack, b_err;
    logic [DL-1:0]  b_rdata;
    logic [ADL-1:0] ram_address;
    logic [DL-1:0]  ram_datain;
    logic [DL-1:0]  ram_dataout;
    logic           ram_read, ram_write;

    int checks = 0;
    int errors = 0;

    ram_arbiter #(
        .ADLINES(ADL), .DATALINES(DL), .RAM_SIZE(255), .RAM_WAIT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .ram_address(ram_address), .ram_datain(ram_datain), .ram_dataout(ram_dataout),
        .ram_read(ram_read), .ram_write(ram_write)
    );

    always #5 clk = ~clk;

    // RAM model: combinational read, write on rising edge, plus a preload port.
    logic [DL-1:0]  mem [256];
    logic           pl_we = 1'b0;
    logic [ADL-1:0] pl_addr = '0;
    logic [DL-1:0]  pl_data = '0;
    assign ram_dataout = mem[ram_address];
    always @(posedge clk) begin
        if (ram_write) mem[ram_address] <= ram_datain;
        else if (pl_we) mem[pl_addr] <= pl_data;
    end

    // Strobe monitor, sampled mid-cycle.
    int             rd_cyc = 0, wr_cyc = 0, overlap = 0;
    logic [ADL-1:0] last_wr_addr = '0;
    always @(negedge clk) begin
        if (ram_read) rd_cyc <= rd_cyc + 1;
        if (ram_write) begin
            wr_cyc <= wr_cyc + 1;
            last_wr_addr <= ram_address;
        end
        if (ram_read && ram_write) overlap <= overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [ADL-1:0] addr, input logic [DL-1:0] data);
        pl_addr = addr;
        pl_data = data;
        pl_we   = 1'b1;
        @(posedge clk); #1;
        pl_we   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Count edges until the chosen ack is seen; 1 = ack right after the first edge.
    task automatic wait_ack(input bit port_b, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            cycles++;
            seen = port_b ? b_ack : a_ack;
        end
        if (!seen) check("ack_timeout", 32'd0, 32'd1);
    endtask

    int cyc;
    int rd0, wr0;

    initial begin
        #3 rst_n = 1'b0;
        preload(8'h05, 16'h1234);
        preload(8'h20, 16'hAAAA);
        preload(8'h30, 16'h5555);
        preload(8'hFE, 16'hCAFE);
        preload(8'h40, 16'h7777);
        check("rst_acks",  {30'd0, a_ack, b_ack}, 32'd0);
        check("rst_errs",  {30'd0, a_err, b_err}, 32'd0);
        check("rst_rdata", {a_rdata, b_rdata}, 32'd0);
        check("rst_ram",   {6'd0, ram_read, ram_write, ram_address, ram_datain}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // A read of 0x05
        rd0 = rd_cyc;
        a_addr = 8'h05; a_req = 1'b1;
        tick();
        check("a_rd_strobe1", {31'd0, ram_read}, 32'd1);
        check("a_rd_addr", {24'd0, ram_address}, 32'h05);
        check("a_rd_nowrite", {31'd0, ram_write}, 32'd0);
        wait_ack(1'b0, cyc);
        check("a_rd_latency", cyc, 32'd2);   // already one edge consumed above
        check("a_rd_data", {16'd0, a_rdata}, 32'h1234);
        check("a_rd_err", {31'd0, a_err}, 32'd0);
        check("a_rd_cycles", rd_cyc - rd0, 32'd2);
        check("a_rd_strobe_off", {31'd0, ram_read}, 32'd0);
        a_req = 1'b0;
        tick();
        check("a_ack_pulse", {31'd0, a_ack}, 32'd0);

        // B write 0xBEEF to 0x10, then read it back
        wr0 = wr_cyc;
        b_addr = 8'h10; b_we = 1'b1; b_wdata = 16'hBEEF; b_req = 1'b1;
        wait_ack(1'b1, cyc);
        check("b_wr_latency", cyc, 32'd3);
        check("b_wr_cycles", wr_cyc - wr0, 32'd2);
        check("b_wr_addr", {24'd0, last_wr_addr}, 32'h10);
        check("b_wr_mem", {16'd0, mem[8'h10]}, 32'hBEEF);
        check("b_wr_err", {31'd0, b_err}, 32'd0);
        b_req = 1'b0;
        tick();
        b_we = 1'b0;
        b_req = 1'b1;
        wait_ack(1'b1, cyc);
        check("b_rd_latency", cyc, 32'd3);
        check("b_rd_data", {16'd0, b_rdata}, 32'hBEEF);
        check("a_rdata_held", {16'd0, a_rdata}, 32'h1234);
        b_req = 1'b0;
        tick();

        // Simultaneous requests
        a_addr = 8'h20; b_addr = 8'h30; b_we = 1'b0;
        a_req = 1'b1; b_req = 1'b1;
`ifdef ROUND_ROBIN_EN
        wait_ack(1'b0, cyc);
        check("rr_first_a", cyc, 32'd3);
        check("rr_b_waits", {31'd0, b_ack}, 32'd0);
        check("rr_a_data", {16'd0, a_rdata}, 32'hAAAA);
        a_req = 1'b0;
        wait_ack(1'b1, cyc);
        check("rr_then_b", cyc, 32'd4);
        check("rr_b_data", {16'd0, b_rdata}, 32'h5555);
        b_req = 1'b0;
`else
        wait_ack(1'b1, cyc);
        check("pri_first_b", cyc, 32'd3);
        check("pri_a_waits", {31'd0, a_ack}, 32'd0);
        check("pri_b_data", {16'd0, b_rdata}, 32'h5555);
        b_req = 1'b0;
        wait_ack(1'b0, cyc);
        check("pri_then_a", cyc, 32'd4);
        check("pri_a_data", {16'd0, a_rdata}, 32'hAAAA);
        a_req = 1'b0;
`endif
        tick();

        // Out-of-range 0xFF (RAM_SIZE = 255)
        rd0 = rd_cyc;
        a_addr = 8'hFF; a_req = 1'b1;
        wait_ack(1'b0, cyc);
        check("oor_latency", cyc, 32'd1);
        check("oor_err", {31'd0, a_err}, 32'd1);
        check("oor_rdata_kept", {16'd0, a_rdata}, 32'hAAAA);
        a_req = 1'b0;
        tick();
        check("oor_no_strobe", rd_cyc - rd0, 32'd0);
        check("oor_err_clear", {31'd0, a_err}, 32'd0);

        // Last valid address 0xFE
        b_addr = 8'hFE; b_we = 1'b0; b_req = 1'b1;
        wait_ack(1'b1, cyc);
        check("edge_latency", cyc, 32'd3);
        check("edge_err", {31'd0, b_err}, 32'd0);
        check("edge_data", {16'd0, b_rdata}, 32'hCAFE);
        b_req = 1'b0;
        tick();

        // Reset during the second ACCESS cycle of a write
        b_addr = 8'h40; b_we = 1'b1; b_wdata = 16'h1111; b_req = 1'b1;
        tick();
        tick();
        check("mid_wr_active", {31'd0, ram_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_write", {31'd0, ram_write}, 32'd0);
        check("mid_rst_addr", {24'd0, ram_address}, 32'd0);
        check("mid_rst_data", {16'd0, ram_datain}, 32'd0);
        check("mid_rst_rdata", {a_rdata, b_rdata}, 32'd0);
        tick();
        check("mid_rst_noack", {30'd0, a_ack, b_ack}, 32'd0);
        rst_n = 1'b1;
        wr0 = wr_cyc;
        wait_ack(1'b1, cyc);
        check("reserve_latency", cyc, 32'd3);
        check("reserve_cycles", wr_cyc - wr0, 32'd2);
        check("reserve_mem", {16'd0, mem[8'h40]}, 32'h1111);
        b_req = 1'b0;
        tick();
        tick();

        check("strobe_overlap", overlap, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
